fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program counter and fetch sequencer for the 9-bit core; sits directly downstream of the control decoder and consumes its branch_en.
- Holds the PC that addresses instruction ROM and advances it by +1, by a signed relative offset (kBRR), or to an absolute target from an internal branch-target LUT (kBRC).
- Sequences program start, halt and completion with a small FSM.

Parameters:
- PC_W, 10, PC width in bits; instruction ROM depth is 2^PC_W.
- LUT_AW, 5, branch-target LUT address width; the LUT has 2^LUT_AW entries of PC_W bits.
- START_ADDR, 0, PC value loaded on reset and on every Start.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Start  input  1  begin program execution from START_ADDR.
- Halt  input  1  current instruction is the halt opcode (from the decoder).
- Stall  input  1  hold the PC this cycle (downstream not ready).
- Branch_en  input  1  branch taken, from the control decoder.
- Branch_abs  input  1  1 = absolute branch via LUT (kBRC); 0 = relative branch (kBRR).
- Target  input  LUT_AW  Instruction[4:0]: LUT index when Branch_abs=1, signed offset when Branch_abs=0.
- Lut_wr_en  input  1  write enable for the branch-target LUT.
- Lut_wr_addr  input  LUT_AW  LUT write index.
- Lut_wr_data  input  PC_W  LUT write value.
- PC  output  PC_W  instruction ROM address.
- Fetch_valid  output  1  PC addresses a live instruction this cycle.
- Done  output  1  program has halted.

Behaviour:
- Reset (Reset_n=0 at a rising edge), wins over every other input:
  - State = IDLE, PC = START_ADDR, Fetch_valid = 0, Done = 0.
  - All LUT entries = 0.
  - Applies mid-operation in any state.
- FSM states: IDLE, RUN, DONE.
  - IDLE: PC holds. Start -> RUN with PC = START_ADDR.
  - RUN: Fetch_valid = ~Stall.
  - DONE: Done = 1, PC holds. Start -> RUN with PC = START_ADDR and Done cleared in the same edge.
- Start in RUN is ignored.
- PC update in RUN, one-cycle latency (inputs sampled at edge n set PC after edge n), priority high to low:
  1. Stall=1: PC holds; Halt and Branch_en are ignored this cycle.
  2. Halt=1: PC holds, state -> DONE. Halt beats a simultaneous Branch_en.
  3. Branch_en=1 and Branch_abs=1: PC = LUT[Target].
  4. Branch_en=1 and Branch_abs=0: PC = PC + sign_extend(Target), modulo 2^PC_W.
  5. Otherwise: PC = PC + 1, modulo 2^PC_W.
- Arithmetic and boundaries:
  - Relative offset range is -16..+15. An offset of 0 holds the PC (a legal self-loop).
  - Wrap-around past 2^PC_W-1 or below 0 is silent; there is no error flag.
- LUT:
  - Writes are accepted in every state except during reset.
  - The read is combinational from registered contents, so a write and an absolute branch to the same index in the same cycle uses the old entry; the new value is visible from the next cycle.
- Halt, Branch_en and Stall are ignored outside RUN.

Test Plan:
- Reset then Start, no branches, 4 cycles -> PC = 0, 1, 2, 3, 4; Fetch_valid = 1 from the first cycle after Start; Done = 0.
- LUT[3] = 0x2A0 written in IDLE; in RUN at PC = 5, Branch_en=1, Branch_abs=1, Target=3 -> next PC = 0x2A0. Same-cycle write of LUT[3] = 0x111 with the branch -> PC still 0x2A0, and a second branch next cycle -> PC = 0x111.
- Relative branches:
  - PC = 0x010, Target = 5'b11100 (-4) -> PC = 0x00C.
  - PC = 0x3FE, Target = +3 -> PC = 0x001 (wrap).
  - PC = 0x000, no branch, after 0x3FF -> PC = 0x000.
- At PC = 7, Halt=1 and Branch_en=1 in the same cycle -> PC stays 7, Done = 1, Fetch_valid = 0. Start next cycle -> PC = 0, Done = 0.
- Stall=1 for 3 cycles at PC = 9 with Branch_en=1 asserted -> PC holds 9 and Fetch_valid = 0. After the Stall drop with no branch -> PC = 10.
- Reset_n=0 mid-RUN at PC = 0x155 -> next edge PC = 0, state IDLE, LUT[3] reads 0, Done = 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: decoder/control inputs, LUT write port, and PC/status outputs.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              branch_en;
  logic              branch_abs;
  logic [LUT_AW-1:0] target;
  logic              lut_wr_en;
  logic [LUT_AW-1:0] lut_wr_addr;
  logic [PC_W-1:0]   lut_wr_data;
  logic [PC_W-1:0]   pc;
  logic              fetch_valid;
  logic              done;

  modport master (
    output start, halt, stall, branch_en, branch_abs, target,
    output lut_wr_en, lut_wr_addr, lut_wr_data,
    input  pc, fetch_valid, done
  );

  modport slave (
    input  start, halt, stall, branch_en, branch_abs, target,
    input  lut_wr_en, lut_wr_addr, lut_wr_data,
    output pc, fetch_valid, done
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: +1, relative (kBRR) and LUT-absolute (kBRC) branches,
// with an idle/run/done FSM controlling start, halt and completion.
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_AW     = 5,
  parameter int unsigned START_ADDR = 0
) (
  input logic         clk,
  input logic         reset_n,
  fetch_unit_if.slave bus
);
   localparam int unsigned LutDepth = 2 ** LUT_AW;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   lut_q [LutDepth];
   logic [PC_W-1:0]   rel_off;

   // Target doubles as a signed 5-bit offset for relative branches.
   assign rel_off = {{(PC_W - LUT_AW){bus.target[LUT_AW-1]}}, bus.target};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         pc_q    <= PC_W'(START_ADDR);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Registered LUT: a same-cycle write and read of one entry returns the old value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(LutDepth); i++) begin
            lut_q[i] <= '0;
         end
      end else if (bus.lut_wr_en) begin
         lut_q[bus.lut_wr_addr] <= bus.lut_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StRun;
               pc_d    = PC_W'(START_ADDR);
            end
         end
         StRun: begin
            if (!bus.stall) begin
               if (bus.halt) begin
                  state_d = StDone;
               end else if (bus.branch_en) begin
                  if (bus.branch_abs) pc_d = lut_q[bus.target];
                  else                pc_d = pc_q + rel_off;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = (state_q == StRun) && !bus.stall;
   assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequencing, LUT/relative branches, halt, stall,
// and reset behaviour.
module tb_fetch_unit;
   localparam int unsigned PC_W   = 10;
   localparam int unsigned LUT_AW = 5;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   fetch_unit_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

   fetch_unit #(
     .PC_W       (PC_W),
     .LUT_AW     (LUT_AW),
     .START_ADDR (0)
   ) dut (
     .clk     (clk),
     .reset_n (reset_n),
     .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start       = 1'b0;
      bus.halt        = 1'b0;
      bus.stall       = 1'b0;
      bus.branch_en   = 1'b0;
      bus.branch_abs  = 1'b0;
      bus.target      = '0;
      bus.lut_wr_en   = 1'b0;
      bus.lut_wr_addr = '0;
      bus.lut_wr_data = '0;
   endtask

   // Stimulus only: load LUT[idx] = addr, then take an absolute branch through it.
   task automatic jump_to(input logic [LUT_AW-1:0] idx, input logic [PC_W-1:0] addr);
      bus.lut_wr_en   = 1'b1;
      bus.lut_wr_addr = idx;
      bus.lut_wr_data = addr;
      step();
      bus.lut_wr_en   = 1'b0;
      bus.branch_en   = 1'b1;
      bus.branch_abs  = 1'b1;
      bus.target      = idx;
      step();
      clear_inputs();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      step();
      step();
      n_checks++;
      if (bus.pc !== 10'h000) begin
         $display("FAIL reset_pc actual=%h required=%h", bus.pc, 10'h000); n_fail++;
      end
      n_checks++;
      if (bus.fetch_valid !== 1'b0) begin
         $display("FAIL reset_fetch_valid actual=%b required=0", bus.fetch_valid); n_fail++;
      end
      n_checks++;
      if (bus.done !== 1'b0) begin
         $display("FAIL reset_done actual=%b required=0", bus.done); n_fail++;
      end
      reset_n = 1'b1;
      step();
      n_checks++;
      if (bus.pc !== 10'h000 || bus.fetch_valid !== 1'b0) begin
         $display("FAIL idle_hold actual pc=%h fv=%b required pc=000 fv=0", bus.pc,
                  bus.fetch_valid); n_fail++;
      end
   endtask

   task automatic test_sequential();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n_checks++;
      if (bus.pc !== 10'h000 || bus.fetch_valid !== 1'b1 || bus.done !== 1'b0) begin
         $display("FAIL start actual pc=%h fv=%b done=%b required pc=000 fv=1 done=0",
                  bus.pc, bus.fetch_valid, bus.done); n_fail++;
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         n_checks++;
         if (bus.pc !== PC_W'(i) || bus.fetch_valid !== 1'b1 || bus.done !== 1'b0) begin
            $display("FAIL seq_pc%0d actual pc=%h fv=%b required pc=%h fv=1", i, bus.pc,
                     bus.fetch_valid, PC_W'(i)); n_fail++;
         end
      end
   endtask

   task automatic test_lut_abs();
      reset_n = 1'b0;
      clear_inputs();
      step();
      reset_n = 1'b1;
      bus.lut_wr_en   = 1'b1;
      bus.lut_wr_addr = 5'd3;
      bus.lut_wr_data = 10'h2A0;
      step();
      bus.lut_wr_en = 1'b0;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (bus.pc !== 10'h005) begin
         $display("FAIL abs_pre actual=%h required=%h", bus.pc, 10'h005); n_fail++;
      end
      bus.branch_en   = 1'b1;
      bus.branch_abs  = 1'b1;
      bus.target      = 5'd3;
      bus.lut_wr_en   = 1'b1;
      bus.lut_wr_addr = 5'd3;
      bus.lut_wr_data = 10'h111;
      step();
      bus.lut_wr_en = 1'b0;
      n_checks++;
      if (bus.pc !== 10'h2A0) begin
         $display("FAIL abs_old_entry actual=%h required=%h", bus.pc, 10'h2A0); n_fail++;
      end
      step();
      n_checks++;
      if (bus.pc !== 10'h111) begin
         $display("FAIL abs_new_entry actual=%h required=%h", bus.pc, 10'h111); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_relative();
      jump_to(5'd1, 10'h010);
      bus.branch_en  = 1'b1;
      bus.branch_abs = 1'b0;
      bus.target     = 5'b11100;
      step();
      n_checks++;
      if (bus.pc !== 10'h00C) begin
         $display("FAIL rel_neg actual=%h required=%h", bus.pc, 10'h00C); n_fail++;
      end
      bus.target = 5'b00000;
      step();
      n_checks++;
      if (bus.pc !== 10'h00C) begin
         $display("FAIL rel_zero actual=%h required=%h", bus.pc, 10'h00C); n_fail++;
      end
      clear_inputs();
      jump_to(5'd2, 10'h3FE);
      bus.branch_en = 1'b1;
      bus.target    = 5'd3;
      step();
      n_checks++;
      if (bus.pc !== 10'h001) begin
         $display("FAIL rel_wrap actual=%h required=%h", bus.pc, 10'h001); n_fail++;
      end
      clear_inputs();
      jump_to(5'd2, 10'h3FE);
      step();
      step();
      n_checks++;
      if (bus.pc !== 10'h000) begin
         $display("FAIL inc_wrap actual=%h required=%h", bus.pc, 10'h000); n_fail++;
      end
   endtask

   task automatic test_halt();
      jump_to(5'd4, 10'h007);
      bus.halt       = 1'b1;
      bus.branch_en  = 1'b1;
      bus.branch_abs = 1'b0;
      bus.target     = 5'd5;
      step();
      clear_inputs();
      n_checks++;
      if (bus.pc !== 10'h007 || bus.done !== 1'b1 || bus.fetch_valid !== 1'b0) begin
         $display("FAIL halt actual pc=%h done=%b fv=%b required pc=007 done=1 fv=0",
                  bus.pc, bus.done, bus.fetch_valid); n_fail++;
      end
      bus.branch_en = 1'b1;
      step();
      n_checks++;
      if (bus.pc !== 10'h007 || bus.done !== 1'b1) begin
         $display("FAIL done_hold actual pc=%h done=%b required pc=007 done=1", bus.pc,
                  bus.done); n_fail++;
      end
      clear_inputs();
      bus.start = 1'b1;
      step();
      n_checks++;
      if (bus.pc !== 10'h000 || bus.done !== 1'b0 || bus.fetch_valid !== 1'b1) begin
         $display("FAIL restart actual pc=%h done=%b fv=%b required pc=000 done=0 fv=1",
                  bus.pc, bus.done, bus.fetch_valid); n_fail++;
      end
      step();
      n_checks++;
      if (bus.pc !== 10'h001) begin
         $display("FAIL start_in_run actual=%h required=%h", bus.pc, 10'h001); n_fail++;
      end
      clear_inputs();
   endtask

   task automatic test_stall();
      jump_to(5'd5, 10'h009);
      bus.stall     = 1'b1;
      bus.branch_en = 1'b1;
      bus.target    = 5'd3;
      #1;
      n_checks++;
      if (bus.fetch_valid !== 1'b0) begin
         $display("FAIL stall_fv actual=%b required=0", bus.fetch_valid); n_fail++;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (bus.pc !== 10'h009 || bus.fetch_valid !== 1'b0) begin
            $display("FAIL stall_hold%0d actual pc=%h fv=%b required pc=009 fv=0", i, bus.pc,
                     bus.fetch_valid); n_fail++;
         end
      end
      clear_inputs();
      #1;
      n_checks++;
      if (bus.fetch_valid !== 1'b1) begin
         $display("FAIL unstall_fv actual=%b required=1", bus.fetch_valid); n_fail++;
      end
      step();
      n_checks++;
      if (bus.pc !== 10'h00A) begin
         $display("FAIL unstall_pc actual=%h required=%h", bus.pc, 10'h00A); n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      jump_to(5'd6, 10'h155);
      n_checks++;
      if (bus.pc !== 10'h155) begin
         $display("FAIL mid_pre actual=%h required=%h", bus.pc, 10'h155); n_fail++;
      end
      reset_n       = 1'b0;
      bus.branch_en = 1'b1;
      step();
      clear_inputs();
      reset_n = 1'b1;
      n_checks++;
      if (bus.pc !== 10'h000 || bus.done !== 1'b0 || bus.fetch_valid !== 1'b0) begin
         $display("FAIL mid_reset actual pc=%h done=%b fv=%b required pc=000 done=0 fv=0",
                  bus.pc, bus.done, bus.fetch_valid); n_fail++;
      end
      bus.halt = 1'b1;
      step();
      n_checks++;
      if (bus.pc !== 10'h000 || bus.done !== 1'b0) begin
         $display("FAIL mid_idle actual pc=%h done=%b required pc=000 done=0", bus.pc,
                  bus.done); n_fail++;
      end
      clear_inputs();
      bus.start = 1'b1;
      step();
      clear_inputs();
      bus.branch_en  = 1'b1;
      bus.branch_abs = 1'b1;
      bus.target     = 5'd3;
      step();
      clear_inputs();
      n_checks++;
      if (bus.pc !== 10'h000) begin
         $display("FAIL lut_cleared actual=%h required=%h", bus.pc, 10'h000); n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      clear_inputs();
      test_reset();
      test_sequential();
      test_lut_abs();
      test_relative();
      test_halt();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
